// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bus: redirect/dequeue from the pipeline plus the instruction-memory port.
// slave is the fetch queue itself; master is whatever drives it.
interface instr_fetch_queue_if;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        deq_i;
    logic        valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_n_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_rdy_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport slave (
        input  redirect_i, redirect_pc_i, deq_i, mem_rdy_i, mem_rvalid_i, mem_rdata_i,
        output valid_o, instr_o, pc_n_o, mem_req_o, mem_addr_o
    );

    modport master (
        output redirect_i, redirect_pc_i, deq_i, mem_rdy_i, mem_rvalid_i, mem_rdata_i,
        input  valid_o, instr_o, pc_n_o, mem_req_o, mem_addr_o
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Decoupled instruction fetch: owns the fetch PC, keeps one memory request in flight
// and buffers {pc+4, instr} pairs for the IF stage; redirects flush and squash stale data.
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                  clk_i,
    input logic                  rst_i,
    instr_fetch_queue_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    state_t          state, state_n;
    logic [31:0]     fetch_pc, req_pc;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     count;
    logic [31:0]     pcn_mem   [DEPTH];
    logic [31:0]     instr_mem [DEPTH];
    logic            in_wait, credit_ok, req, accept, push, pop;

    // An outstanding request already owns a slot; a same-cycle dequeue is not credited.
    assign in_wait   = (state == WAIT);
    assign credit_ok = ({1'b0, count} + {{(PW+1){1'b0}}, in_wait}) < (PW+2)'(DEPTH);

    // Requests are also held off while reset is asserted so the port is quiet in reset.
    assign req    = !rst_i && !bus.redirect_i && credit_ok &&
                    ((state == IDLE) || (in_wait && bus.mem_rvalid_i));
    assign accept = req && bus.mem_rdy_i;
    assign push   = in_wait && bus.mem_rvalid_i && !bus.redirect_i;
    assign pop    = bus.deq_i && (count != '0) && !bus.redirect_i;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = WAIT;
            WAIT: begin
                if (bus.redirect_i)        state_n = bus.mem_rvalid_i ? IDLE : DISCARD;
                else if (bus.mem_rvalid_i) state_n = accept ? WAIT : IDLE;
            end
            DISCARD: if (bus.mem_rvalid_i) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (bus.redirect_i) begin
            fetch_pc <= bus.redirect_pc_i & ~32'h3;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (accept) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            pcn_mem[wr_ptr]   <= req_pc + 32'd4;
            instr_mem[wr_ptr] <= bus.mem_rdata_i;
        end
    end

    assign bus.valid_o    = (count != '0);
    assign bus.instr_o    = bus.valid_o ? instr_mem[rd_ptr] : 32'h0;
    assign bus.pc_n_o     = bus.valid_o ? pcn_mem[rd_ptr]   : 32'h0;
    assign bus.mem_req_o  = req;
    assign bus.mem_addr_o = fetch_pc;
endmodule
